// File: rtl/ili_bus_engine.sv
`default_nettype none
// ============================================================================
// ili_bus_engine : Avalon-MM slave running ILI93xx 8080-style 16-bit bus cycles
// Revision 1.0
// ============================================================================
module ili_bus_engine #(
  parameter int T_WRL = 2,
  parameter int T_WRH = 2,
  parameter int T_RDL = 8,
  parameter int T_RDH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        waitrequest,
  output logic        lcd_cs_n,
  output logic        lcd_rs,
  output logic        lcd_wr_n,
  output logic        lcd_rd_n,
  output logic [15:0] lcd_data_out,
  output logic        lcd_data_oe,
  input  logic [15:0] lcd_data_in
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [7:0] c_wrl = 8'(T_WRL - 1);
  localparam logic [7:0] c_wrh = 8'(T_WRH - 1);
  localparam logic [7:0] c_rdl = 8'(T_RDL - 1);
  localparam logic [7:0] c_rdh = 8'(T_RDH - 1);

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [7:0]  r_cnt;
  logic        r_op_write;

  logic        w_req;
  logic        w_req_write;
  logic        w_valid;
  logic        w_op_write;
  logic        w_bus_active;

  logic        w_cs_n_nxt;
  logic        w_rs_nxt;
  logic        w_wr_n_nxt;
  logic        w_rd_n_nxt;
  logic [15:0] w_data_nxt;
  logic        w_oe_nxt;
  logic [15:0] w_rdata_nxt;

  // Write strobe takes priority when both strobes are asserted.
  assign w_req       = chipselect & (~write_n | ~read_n);
  assign w_req_write = ~write_n;
  assign w_valid     = w_req_write ? (address[1] == 1'b0) : (address == 2'd2);
  assign w_op_write  = (r_state == S_IDLE) ? w_req_write : r_op_write;
  assign waitrequest = w_req & (r_state != S_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_req) w_next = w_valid ? S_SETUP : S_DONE;
      S_SETUP:  w_next = S_STROBE;
      S_STROBE: if (r_cnt == 8'd0) w_next = S_HOLD;
      S_HOLD:   if (r_cnt == 8'd0) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Phase counter is loaded with T-1 on entry to each timed phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= 8'd0;
      r_op_write <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_req) r_op_write <= w_req_write;
      if (w_next == S_STROBE && r_state != S_STROBE)
        r_cnt <= r_op_write ? c_wrl : c_rdl;
      else if (w_next == S_HOLD && r_state != S_HOLD)
        r_cnt <= r_op_write ? c_wrh : c_rdh;
      else if (r_cnt != 8'd0)
        r_cnt <= r_cnt - 8'd1;
    end
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    w_bus_active = (w_next == S_SETUP) || (w_next == S_STROBE) || (w_next == S_HOLD);
    w_cs_n_nxt   = ~w_bus_active;
    w_wr_n_nxt   = ~((w_next == S_STROBE) &&  w_op_write);
    w_rd_n_nxt   = ~((w_next == S_STROBE) && !w_op_write);
    w_oe_nxt     = w_bus_active && w_op_write;
    w_rs_nxt     = lcd_rs;
    w_data_nxt   = lcd_data_out;
    w_rdata_nxt  = readdata;
    if (r_state == S_IDLE && w_next == S_SETUP) begin
      w_rs_nxt = (address != 2'd0);
      if (w_req_write) w_data_nxt = writedata;
    end
    if (r_state == S_STROBE && w_next == S_HOLD && !r_op_write)
      w_rdata_nxt = lcd_data_in;
    else if (r_state == S_IDLE && w_next == S_DONE && !w_req_write)
      w_rdata_nxt = 16'h0000;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lcd_cs_n     <= 1'b1;
      lcd_rs       <= 1'b1;
      lcd_wr_n     <= 1'b1;
      lcd_rd_n     <= 1'b1;
      lcd_data_out <= 16'h0000;
      lcd_data_oe  <= 1'b0;
      readdata     <= 16'h0000;
    end else begin
      lcd_cs_n     <= w_cs_n_nxt;
      lcd_rs       <= w_rs_nxt;
      lcd_wr_n     <= w_wr_n_nxt;
      lcd_rd_n     <= w_rd_n_nxt;
      lcd_data_out <= w_data_nxt;
      lcd_data_oe  <= w_oe_nxt;
      readdata     <= w_rdata_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ili_bus_engine.sv
`default_nettype none
// ============================================================================
// tb_ili_bus_engine : directed scoreboard bench for ili_bus_engine
// Revision 1.0
// ============================================================================
module tb_ili_bus_engine;

  localparam int T_WRL = 2;
  localparam int T_WRH = 2;
  localparam int T_RDL = 8;
  localparam int T_RDH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic        read_n = 1'b1;
  logic [15:0] writedata = 16'h0000;
  logic [15:0] readdata;
  logic        waitrequest;
  logic        lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_data_oe;
  logic [15:0] lcd_data_out;
  logic [15:0] lcd_data_in = 16'h0000;

  typedef struct {
    int          wait_cyc;
    int          wr_low;
    int          rd_low;
    int          cs_low;
    int          oe_cyc;
    logic [15:0] rd;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] model_rd = 16'h0000;

  ili_bus_engine #(.T_WRL(T_WRL), .T_WRH(T_WRH), .T_RDL(T_RDL), .T_RDH(T_RDH)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
    .waitrequest(waitrequest), .lcd_cs_n(lcd_cs_n), .lcd_rs(lcd_rs),
    .lcd_wr_n(lcd_wr_n), .lcd_rd_n(lcd_rd_n), .lcd_data_out(lcd_data_out),
    .lcd_data_oe(lcd_data_oe), .lcd_data_in(lcd_data_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete Avalon transfer; expectations are queued before the request is driven.
  task automatic access(input string name, input logic [1:0] a, input bit wr,
                        input logic [15:0] wd, input logic [15:0] din, output int pre_high);
    exp_t e, got;
    bit   valid, seen_low;
    int   tl, th, cyc, wl, rl, cl, oc, bad_rs, bad_d;
    valid      = wr ? (a <= 2'd1) : (a == 2'd2);
    tl         = wr ? T_WRL : T_RDL;
    th         = wr ? T_WRH : T_RDH;
    e.wait_cyc = valid ? 2 + tl + th : 1;
    e.cs_low   = valid ? 1 + tl + th : 0;
    e.wr_low   = (valid && wr) ? T_WRL : 0;
    e.rd_low   = (valid && !wr) ? T_RDL : 0;
    e.oe_cyc   = (valid && wr) ? 1 + tl + th : 0;
    if (!wr) model_rd = valid ? din : 16'h0000;
    e.rd       = model_rd;
    sb.push_back(e);

    @(negedge clk);
    address     = a;
    writedata   = wd;
    lcd_data_in = din;
    write_n     = ~wr;
    read_n      = wr;
    chipselect  = 1'b1;
    #1;
    cyc = 0; wl = 0; rl = 0; cl = 0; oc = 0; bad_rs = 0; bad_d = 0;
    pre_high = 0; seen_low = 0;
    forever begin
      if (lcd_cs_n === 1'b0) begin
        cl++;
        seen_low = 1;
        if (lcd_rs !== (a != 2'd0)) bad_rs++;
      end else if (!seen_low) begin
        pre_high++;
      end
      if (lcd_wr_n === 1'b0) wl++;
      if (lcd_rd_n === 1'b0) rl++;
      if (lcd_data_oe === 1'b1) begin
        oc++;
        if (lcd_data_out !== wd) bad_d++;
      end
      if (waitrequest !== 1'b1 || cyc >= 200) break;
      @(negedge clk);
      #1;
      cyc++;
    end

    got = sb.pop_front();
    check({name, ".wait_cycles"}, cyc, got.wait_cyc);
    check({name, ".cs_low"}, cl, got.cs_low);
    check({name, ".wr_low"}, wl, got.wr_low);
    check({name, ".rd_low"}, rl, got.rd_low);
    check({name, ".oe_cycles"}, oc, got.oe_cyc);
    check({name, ".rs_bad"}, bad_rs, 0);
    check({name, ".data_bad"}, bad_d, 0);
    check({name, ".done_cs_n"}, {31'd0, lcd_cs_n}, 1);
    check({name, ".readdata"}, {16'd0, readdata}, {16'd0, got.rd});

    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    read_n     = 1'b1;
  endtask

  initial begin
    int ph;
    int k;
    int wl;

    repeat (3) @(negedge clk);
    #1;
    check("rst.cs_n", {31'd0, lcd_cs_n}, 1);
    check("rst.wr_n", {31'd0, lcd_wr_n}, 1);
    check("rst.rd_n", {31'd0, lcd_rd_n}, 1);
    check("rst.rs", {31'd0, lcd_rs}, 1);
    check("rst.oe", {31'd0, lcd_data_oe}, 0);
    check("rst.data_out", {16'd0, lcd_data_out}, 0);
    check("rst.readdata", {16'd0, readdata}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    access("cmd_wr", 2'd0, 1'b1, 16'h0022, 16'h0000, ph);
    access("dat_wr", 2'd1, 1'b1, 16'hF800, 16'h0000, ph);
    access("dat_rd", 2'd2, 1'b0, 16'h0000, 16'h9325, ph);

    access("b2b_a", 2'd0, 1'b1, 16'h002A, 16'h0000, ph);
    access("b2b_b", 2'd1, 1'b1, 16'h1234, 16'h0000, ph);
    check("b2b.gap_ge2", {31'd0, (1 + ph) >= 2}, 1);

    access("bad_wr3", 2'd3, 1'b1, 16'hFFFF, 16'h0000, ph);
    access("bad_rd0", 2'd0, 1'b0, 16'h0000, 16'hBEEF, ph);
    access("bad_wr2", 2'd2, 1'b1, 16'h5555, 16'h0000, ph);
    access("rd_a2", 2'd2, 1'b0, 16'h0000, 16'h0F0F, ph);
    access("status", 2'd3, 1'b0, 16'h0000, 16'hAAAA, ph);

    // Asynchronous reset in the middle of a write strobe.
    @(negedge clk);
    address = 2'd1; writedata = 16'hABCD; write_n = 1'b0; chipselect = 1'b1;
    k = 0;
    #1;
    while (lcd_wr_n !== 1'b0 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("arst.strobe_seen", {31'd0, lcd_wr_n}, 0);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst.wr_n", {31'd0, lcd_wr_n}, 1);
    check("arst.cs_n", {31'd0, lcd_cs_n}, 1);
    check("arst.oe", {31'd0, lcd_data_oe}, 0);
    check("arst.data_out", {16'd0, lcd_data_out}, 0);
    chipselect = 1'b0; write_n = 1'b1;
    model_rd = 16'h0000;
    @(negedge clk);
    reset_n = 1'b1;
    access("post_rst_wr", 2'd1, 1'b1, 16'h07E0, 16'h0000, ph);

    // Master drops the request mid-cycle; the bus cycle must still finish.
    @(negedge clk);
    address = 2'd0; writedata = 16'h002C; write_n = 1'b0; chipselect = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    wl = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (lcd_wr_n === 1'b0) wl++;
      @(negedge clk);
    end
    check("drop.wr_low", wl, T_WRL);
    check("drop.cs_n_idle", {31'd0, lcd_cs_n}, 1);
    access("drop_after", 2'd2, 1'b0, 16'h0000, 16'h1111, ph);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
